// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- self-test sequencer for a single-port RAM.
// Issues one RAM op per cycle, compares read data, logs first failure.
module mbist_march_ctrl #(
   parameter int AW     = 6,
   parameter int DW     = 8,
   parameter int RD_LAT = 1,
   parameter int NUM_BG = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          mem_cs,
   output logic          mem_rwbar,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [2:0]    fail_elem,
   output logic [1:0]    fail_bg,
   output logic [7:0]    err_cnt
);

   localparam logic [1:0] BG_LAST  = 2'(NUM_BG - 1);
   localparam logic [1:0] DRN_INIT = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [DW-1:0] exp;
      logic [AW-1:0] addr;
      logic [2:0]    elem;
      logic [1:0]    bg;
   } cmp_t;

   state_t            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic              ph_q, ph_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [1:0]        bg_q, bg_d;
   logic [1:0]        drn_q, drn_d;
   logic              cs_q, cs_d;
   logic              rw_q, rw_d;
   logic [DW-1:0]     wd_q, wd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic [AW-1:0]     faddr_q, faddr_d;
   logic [2:0]        felem_q, felem_d;
   logic [1:0]        fbg_q, fbg_d;
   logic [7:0]        ecnt_q, ecnt_d;
   logic [RD_LAT-1:0] pv_q, pv_d;
   cmp_t              pe_q [RD_LAT];
   cmp_t              pe_d [RD_LAT];

   logic              op_end;
   logic              down;
   logic              addr_end;
   logic              last_op;
   logic [2:0]        n_elem;
   logic              n_ph;
   logic [AW-1:0]     n_addr;
   logic [1:0]        n_bg;
   logic              miscmp;

   function automatic logic [DW-1:0] bg_pat(input logic [1:0] b);
      logic [DW-1:0] p;
      p = '0;
      for (int i = 0; i < DW; i++) begin
         case (b)
            2'd0:    p[i] = 1'b0;
            2'd1:    p[i] = (i % 2) == 0;
            2'd2:    p[i] = ((i / 2) % 2) == 0;
            default: p[i] = ((i / 4) % 2) == 0;
         endcase
      end
      return p;
   endfunction

   // M1 and M3 write the inverse background, the rest write it true
   function automatic logic [DW-1:0] wr_data(input logic [2:0] e,
                                             input logic [1:0] b);
      return (e == 3'd1 || e == 3'd3) ? ~bg_pat(b) : bg_pat(b);
   endfunction

   // M2 and M4 expect the inverse background, the rest expect it true
   function automatic logic [DW-1:0] rd_exp(input logic [2:0] e,
                                            input logic [1:0] b);
      return (e == 3'd2 || e == 3'd4) ? ~bg_pat(b) : bg_pat(b);
   endfunction

   // Step the march order one op past the op now on the bus
   always_comb begin
      op_end   = (elem_q == 3'd0) || (elem_q == 3'd5) || ph_q;
      down     = elem_q >= 3'd3;
      addr_end = down ? (addr_q == '0) : (addr_q == '1);
      last_op  = (elem_q == 3'd5) && addr_end && (bg_q == BG_LAST);
      n_elem   = elem_q;
      n_ph     = 1'b0;
      n_addr   = addr_q;
      n_bg     = bg_q;
      if (!op_end) begin
         n_ph = 1'b1;
      end else if (!addr_end) begin
         n_addr = down ? addr_q - AW'(1) : addr_q + AW'(1);
      end else if (elem_q == 3'd5) begin
         n_elem = 3'd0;
         n_bg   = bg_q + 2'd1;
         n_addr = '0;
      end else begin
         n_elem = elem_q + 3'd1;
         n_addr = (elem_q >= 3'd2) ? '1 : '0;
      end
   end

   // Sequencer state, registered RAM outputs and the compare pipeline
   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      ph_d    = ph_q;
      addr_d  = addr_q;
      bg_d    = bg_q;
      drn_d   = drn_q;
      cs_d    = 1'b0;
      rw_d    = 1'b0;
      wd_d    = '0;
      busy_d  = busy_q;
      done_d  = done_q;
      fail_d  = fail_q;
      faddr_d = faddr_q;
      felem_d = felem_q;
      fbg_d   = fbg_q;
      ecnt_d  = ecnt_q;

      pv_d[0]      = cs_q & rw_q;
      pe_d[0].exp  = rd_exp(elem_q, bg_q);
      pe_d[0].addr = addr_q;
      pe_d[0].elem = elem_q;
      pe_d[0].bg   = bg_q;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         pe_d[i] = pe_q[i-1];
      end

      miscmp = pv_q[RD_LAT-1] && !abort &&
               (mem_rdata != pe_q[RD_LAT-1].exp);
      if (miscmp) begin
         fail_d = 1'b1;
         if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
         end
         if (!fail_q) begin
            faddr_d = pe_q[RD_LAT-1].addr;
            felem_d = pe_q[RD_LAT-1].elem;
            fbg_d   = pe_q[RD_LAT-1].bg;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               ph_d    = 1'b0;
               addr_d  = '0;
               bg_d    = 2'd0;
               cs_d    = 1'b1;
               wd_d    = bg_pat(2'd0);
               busy_d  = 1'b1;
               done_d  = 1'b0;
               fail_d  = 1'b0;
               faddr_d = '0;
               felem_d = 3'd0;
               fbg_d   = 2'd0;
               ecnt_d  = 8'd0;
            end
         end
         S_RUN: begin
            if (last_op) begin
               state_d = S_DRAIN;
               drn_d   = DRN_INIT;
               elem_d  = 3'd0;
               ph_d    = 1'b0;
               addr_d  = '0;
               bg_d    = 2'd0;
            end else begin
               elem_d = n_elem;
               ph_d   = n_ph;
               addr_d = n_addr;
               bg_d   = n_bg;
               cs_d   = 1'b1;
               rw_d   = (n_elem != 3'd0) && !n_ph;
               wd_d   = rw_d ? '0 : wr_data(n_elem, n_bg);
            end
         end
         S_DRAIN: begin
            if (drn_q == 2'd0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               drn_d = drn_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         elem_d  = 3'd0;
         ph_d    = 1'b0;
         addr_d  = '0;
         bg_d    = 2'd0;
         drn_d   = 2'd0;
         cs_d    = 1'b0;
         rw_d    = 1'b0;
         wd_d    = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pv_d    = '0;
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         elem_q  <= 3'd0;
         ph_q    <= 1'b0;
         addr_q  <= '0;
         bg_q    <= 2'd0;
         drn_q   <= 2'd0;
         cs_q    <= 1'b0;
         rw_q    <= 1'b0;
         wd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         faddr_q <= '0;
         felem_q <= 3'd0;
         fbg_q   <= 2'd0;
         ecnt_q  <= 8'd0;
         pv_q    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pe_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         ph_q    <= ph_d;
         addr_q  <= addr_d;
         bg_q    <= bg_d;
         drn_q   <= drn_d;
         cs_q    <= cs_d;
         rw_q    <= rw_d;
         wd_q    <= wd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         faddr_q <= faddr_d;
         felem_q <= felem_d;
         fbg_q   <= fbg_d;
         ecnt_q  <= ecnt_d;
         pv_q    <= pv_d;
         for (int i = 0; i < RD_LAT; i++) begin
            pe_q[i] <= pe_d[i];
         end
      end
   end

   assign mem_cs    = cs_q;
   assign mem_rwbar = rw_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wd_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_addr = faddr_q;
   assign fail_elem = felem_q;
   assign fail_bg   = fbg_q;
   assign err_cnt   = ecnt_q;

endmodule
